// File: rtl/dmem_if.sv
// Load/store handshake bundle between a core (master) and a data-memory responder (slave).
// Request and response each use an independent valid/ready pair.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wmask, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wmask, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, programmable wait states,
// byte-masked writes and word reads on an internal word-organised RAM.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    logic [7:0]   cnt;
    logic [31:0]  addr_q;
    logic [3:0]   wmask_q;
    logic [31:0]  wdata_q;
    logic         rsp_valid_q;
    logic [31:0]  rsp_rdata_q;
    logic         rsp_err_q;

    logic [31:0]  mem [DEPTH_WORDS];

    logic         commit;
    logic         bad_addr;
    logic [AW-1:0] idx;

    // Out-of-range word indices are errors, never aliased onto the RAM.
    assign bad_addr = (addr_q[1:0] != 2'b00) ||
                      ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign idx      = addr_q[AW+1:2];
    assign commit   = (state == WAIT) && (cnt == 8'd0);

    assign bus.req_ready = (state == IDLE) && reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // so the read below sees RAM contents from before any same-edge write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            addr_q      <= '0;
            wmask_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wmask_q <= bus.req_wmask;
                        wdata_q <= bus.req_wdata;
                        cnt     <= 8'(WAIT_CYCLES);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bad_addr;
                        rsp_rdata_q <= (bad_addr || wmask_q != 4'b0000) ? 32'd0 : mem[idx];
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset and power up undefined.
    always_ff @(posedge clk) begin
        if (commit && !bad_addr) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (wmask_q[lane]) mem[idx][8*lane +: 8] <= wdata_q[8*lane +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; three instances cover
// WAIT_CYCLES = 2, 4 and 0, selected one at a time through a shared stimulus port.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        m_req_ready;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_err;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_if if_w2 ();
    dmem_if if_w4 ();
    dmem_if if_w0 ();

    assign if_w2.req_valid = req_valid && (sel == 2'd0);
    assign if_w4.req_valid = req_valid && (sel == 2'd1);
    assign if_w0.req_valid = req_valid && (sel == 2'd2);
    assign if_w2.rsp_ready = rsp_ready && (sel == 2'd0);
    assign if_w4.rsp_ready = rsp_ready && (sel == 2'd1);
    assign if_w0.rsp_ready = rsp_ready && (sel == 2'd2);
    assign if_w2.req_addr  = req_addr;
    assign if_w4.req_addr  = req_addr;
    assign if_w0.req_addr  = req_addr;
    assign if_w2.req_wmask = req_wmask;
    assign if_w4.req_wmask = req_wmask;
    assign if_w0.req_wmask = req_wmask;
    assign if_w2.req_wdata = req_wdata;
    assign if_w4.req_wdata = req_wdata;
    assign if_w0.req_wdata = req_wdata;

    always_comb begin
        m_req_ready = if_w2.req_ready;
        m_rsp_valid = if_w2.rsp_valid;
        m_rsp_rdata = if_w2.rsp_rdata;
        m_rsp_err   = if_w2.rsp_err;
        case (sel)
            2'd1: begin
                m_req_ready = if_w4.req_ready;
                m_rsp_valid = if_w4.rsp_valid;
                m_rsp_rdata = if_w4.rsp_rdata;
                m_rsp_err   = if_w4.rsp_err;
            end
            2'd2: begin
                m_req_ready = if_w0.req_ready;
                m_rsp_valid = if_w0.rsp_valid;
                m_rsp_rdata = if_w0.rsp_rdata;
                m_rsp_err   = if_w0.rsp_err;
            end
            default: ;
        endcase
    end

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .reset(reset), .bus(if_w2.slave));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(4)) u_w4 (.clk(clk), .reset(reset), .bus(if_w4.slave));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .reset(reset), .bus(if_w0.slave));

    function automatic int wait_of(input logic [1:0] s);
        case (s)
            2'd0:    return 2;
            2'd1:    return 4;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns the cycle count of its acceptance edge.
    task automatic send(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                        output int acc);
        int n = 0;
        while (!m_req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!m_req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            acc = -1;
            return;
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_wmask = m;
        req_wdata = d;
        tick();
        acc = cyc;
        // Scramble the request bus to confirm it is sampled only at acceptance.
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFC;
        req_wmask = 4'hF;
        req_wdata = 32'h5A5A_5A5A;
    endtask

    task automatic wait_rsp(output int rc);
        int n = 0;
        while (!m_rsp_valid && n < 300) begin
            tick();
            n++;
        end
        if (!m_rsp_valid) begin
            check("rsp_timeout", 32'd0, 32'd1);
            rc = -1;
        end else begin
            rc = cyc;
        end
    endtask

    task automatic do_req(input string tag, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] d, input logic [31:0] exp_rdata,
                          input logic exp_err, output int acc);
        int rc;
        send(a, m, d, acc);
        wait_rsp(rc);
        check({tag, "_latency"}, 32'(rc - acc), 32'(wait_of(sel) + 1));
        check({tag, "_rdata"}, m_rsp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, m_rsp_err}, {31'd0, exp_err});
        tick();
        check({tag, "_valid_drop"}, {31'd0, m_rsp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, m_req_ready}, 32'd1);
    endtask

    initial begin
        int acc;
        int prev;
        int rc;
        reset     = 1'b0;
        sel       = 2'd0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wmask = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        repeat (3) tick();
        check("rst_req_ready", {31'd0, m_req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        check("rst_rsp_rdata", m_rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'd0, m_rsp_err}, 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_req_ready", {31'd0, m_req_ready}, 32'd1);

        // WAIT_CYCLES=2: write/read, byte masks, errors.
        do_req("wr10",      32'h10,  4'b1111, 32'hDEAD_BEEF, 32'd0,         1'b0, acc);
        do_req("rd10",      32'h10,  4'b0000, 32'd0,         32'hDEAD_BEEF, 1'b0, acc);
        do_req("wr10_mask", 32'h10,  4'b0101, 32'h1122_3344, 32'd0,         1'b0, acc);
        do_req("rd10_mask", 32'h10,  4'b0000, 32'd0,         32'hDE22_BE44, 1'b0, acc);
        do_req("rd_misal",  32'h12,  4'b0000, 32'd0,         32'd0,         1'b1, acc);
        do_req("wr0",       32'h0,   4'b1111, 32'h0123_4567, 32'd0,         1'b0, acc);
        do_req("wr_oor",    32'h400, 4'b1111, 32'hFFFF_FFFF, 32'd0,         1'b1, acc);
        do_req("rd0",       32'h0,   4'b0000, 32'd0,         32'h0123_4567, 1'b0, acc);

        // Backpressure: response held while stalled, new requests refused.
        rsp_ready = 1'b0;
        send(32'h10, 4'b0000, 32'd0, acc);
        wait_rsp(rc);
        req_valid = 1'b1;
        req_addr  = 32'h0;
        req_wmask = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",     {31'd0, m_rsp_valid}, 32'd1);
            check("bp_rdata",     m_rsp_rdata, 32'hDE22_BE44);
            check("bp_req_ready", {31'd0, m_req_ready}, 32'd0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_valid_drop", {31'd0, m_rsp_valid}, 32'd0);
        check("bp_ready_back", {31'd0, m_req_ready}, 32'd1);
        do_req("bp_no_stray", 32'h0, 4'b0000, 32'd0, 32'h0123_4567, 1'b0, acc);

        // WAIT_CYCLES=4: reset during WAIT drops the pending write.
        sel = 2'd1;
        tick();
        do_req("w4_wr20", 32'h20, 4'b1111, 32'h0BAD_C0DE, 32'd0, 1'b0, acc);
        send(32'h20, 4'b1111, 32'hCAFE_F00D, acc);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, m_req_ready}, 32'd0);
        check("midrst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        check("midrst_rsp_rdata", m_rsp_rdata, 32'd0);
        check("midrst_rsp_err",   {31'd0, m_rsp_err}, 32'd0);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        do_req("w4_rd20", 32'h20, 4'b0000, 32'd0, 32'h0BAD_C0DE, 1'b0, acc);

        // WAIT_CYCLES=0: ten back-to-back reads after filling the words.
        sel = 2'd2;
        tick();
        for (int i = 0; i < 10; i++) begin
            do_req("w0_fill", 32'(i * 4), 4'b1111, 32'h1000_0000 + 32'(i * 17), 32'd0, 1'b0, acc);
        end
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            do_req("w0_rd", 32'(i * 4), 4'b0000, 32'd0, 32'h1000_0000 + 32'(i * 17), 1'b0, acc);
            if (i > 0) check("w0_spacing", 32'(acc - prev), 32'd3);
            prev = acc;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the core's data-memory load/store interface.
- Accepts one request at a time over a valid/ready channel, inserts a programmable wait-state latency, and performs a byte-masked write or a word read on an internal word-organised RAM.
- Returns the result over a valid/ready response channel.
- Replaces the zero-latency data memory when the core is moved to a handshaked memory bus; also serves as the memory model for bus-level verification.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..65536.
- WAIT_CYCLES, 2, extra cycles between request acceptance and access commit; 0..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  byte address.
- req_wmask  input  4  byte-write enables, bit i = byte lane i (bits 8i+7:8i); 4'b0000 = read.
- req_wdata  input  32  write data, lane-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- States: IDLE, WAIT, RESP. 2-bit state register and 8-bit wait counter cnt.
- Request, response and error registers are cleared asynchronously while reset=0.
- Reset values: state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not reset.
- req_ready = (state==IDLE) and reset deasserted; it is purely a function of the state.
- IDLE: when req_valid & req_ready, latch addr, wmask and wdata, set cnt=WAIT_CYCLES, go to WAIT. Otherwise stay.
- WAIT with cnt!=0: cnt decrements by 1; no RAM access.
- WAIT with cnt==0, commit edge: go to RESP with rsp_valid=1.
  - Error (latched addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS): no RAM write, rsp_err=1, rsp_rdata=0.
  - Write (wmask!=0): RAM[addr[31:2]] lanes with mask=1 take wdata; lanes with mask=0 are unchanged. rsp_rdata=0, rsp_err=0.
  - Read: rsp_rdata=RAM[addr[31:2]] (pre-edge contents), rsp_err=0.
- Latency: the acceptance edge is E. rsp_valid rises after edge E+WAIT_CYCLES+1. With WAIT_CYCLES=0, the response is valid one cycle after acceptance.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1. On an edge with rsp_valid & rsp_ready, go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- No same-cycle response-to-request overlap: the earliest next acceptance is the cycle after the response handshake. Maximum throughput is one request per WAIT_CYCLES+3 cycles.
- Request inputs are sampled only at the acceptance edge. Changes afterwards are ignored, and req_valid held high while not ready has no effect.
- Response stall: rsp_ready held low keeps the block in RESP indefinitely. Incoming req_valid is not accepted meanwhile.
- Reset mid-operation: an asynchronous reset in WAIT drops the pending request, and the RAM is not written. A reset in RESP drops the response. A write already committed stays in RAM.
- Address wrap: none. Any word index >= DEPTH_WORDS is an error, never aliased.
- A read of a never-written word returns the RAM power-up value, which is undefined in simulation. The bench must write before reading.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write addr 0x10, mask 4'b1111, data 0xDEADBEEF.
  - rsp_valid rises 3 cycles after acceptance with rdata=0 and err=0.
  - A read of 0x10 returns 0xDEADBEEF, err=0.
- Byte masking:
  - Preload 0x10 = 0xDEADBEEF, then write mask 4'b0101, data 0x11223344.
  - A read of 0x10 returns 0xDE22BE44.
- Errors:
  - Read 0x12 gives err=1, rdata=0.
  - Write to 0x400 with DEPTH_WORDS=256 gives err=1, and a read of word 0 is unchanged.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles during a read of 0x10.
  - rsp_valid and rdata stay stable, req_ready=0 throughout.
  - Handshake, then req_ready=1 the next cycle.
- Reset during WAIT:
  - Write 0x20 = 0xCAFEF00D with WAIT_CYCLES=4; pull reset low 1 cycle after acceptance.
  - Outputs clear immediately; a later read of 0x20 returns the prior value.
- WAIT_CYCLES=0 back-to-back:
  - Ten reads with rsp_ready tied high.
  - Each response arrives 1 cycle after acceptance; accepts are spaced 3 cycles apart.
